multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit single-regfile processor datapath.
- Fetches each instruction from instruction memory over a req/ack handshake and decodes the R/I format.
- Drives regfile addresses and write enable, ALU opsel/mode, the two datapath muxes and the data-memory req/ack.
- Owns the program counter and sits between the memories and the regfile/ALU/sign-extend/mux datapath.

Parameters:
- PC_W, 6, PC width; PC wraps from 2**PC_W-1 to 0.
- RESET_PC, 0, PC value after reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction that stops sequencing.

Ports:
- clk  in  1  system clock, rising edge.
- clkreset  in  1  asynchronous active-low reset.
- run  in  1  level; 1 allows sequencing.
- pc  out  PC_W  current program counter.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  instruction word.
- ra1  out  6  regfile read address 1 (rs).
- ra2  out  6  regfile read address 2 (rt for R-type, rd for store).
- wa  out  6  regfile write address (rd).
- rf_we  out  1  regfile write enable.
- alu_opsel  out  3  funct[3:1].
- alu_mode  out  1  funct[0].
- imm  out  15  raw I-type immediate to the sign-extender.
- ms1  out  1  ALU B select: 0 = RD2, 1 = extended imm.
- ms2  out  1  writeback select: 0 = ALU result, 1 = memory read data.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- dmem_ack  in  1  data memory done.
- halted  out  1  HALT state reached.

Behaviour:
- Instruction fields:
  - [0] type: 0 = R, 1 = I.
  - rs = [6:1], rd = [12:7], funct = [16:13].
  - R-type: rt = [22:17]; bits [31:23] ignored.
  - I-type: imm = [31:17].
- I-type funct 4'hE = LOAD, 4'hF = STORE; all other funct values are ALU ops.
- Reset: state IDLE, pc = RESET_PC, all outputs 0. Reset mid-operation aborts the instruction immediately with no write or store issued.
- FSM states and transitions:
  - IDLE: when run = 1, go to FETCH.
  - FETCH: imem_req = 1 until imem_ack. On ack, latch imem_rdata into the instruction register and go to DECODE. imem_req drops in the cycle after ack.
  - DECODE: drive ra1/ra2/wa/imm/alu_opsel/alu_mode from the IR. If IR == HALT_WORD, go to HALT; else go to EXEC.
  - EXEC: ms1 = type. LOAD/STORE go to MEM; all other instructions go to WB.
  - MEM: dmem_req = 1, dmem_we = 1 only for STORE, held until dmem_ack. LOAD then goes to WB with ms2 = 1. STORE retires directly.
  - WB: rf_we = 1 for exactly one cycle unless rd == 0 (r0 is read-only), then retire.
  - HALT: halted = 1. Exits only via reset.
- Retire: pc <= pc + 1, wrapping at 2**PC_W-1 to 0. If run = 1, go to FETCH; else go to IDLE.
- Latency with zero-wait memories (ack in the first req cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- run deassert mid-instruction: the current instruction completes, then the FSM parks in IDLE.
- imem_ack/dmem_ack outside the matching req are ignored.
- ra1/ra2/wa/imm/alu fields hold stable from DECODE until retire.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[31:0] and ret_cnt[31:0].
  - cyc_cnt counts every cycle not in IDLE/HALT.
  - ret_cnt counts retired instructions.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package proc_ctrl_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - FUNCT_LOAD = 4'hE, FUNCT_STORE = 4'hF;
  - instruction field bit-position constants;
  - instr_t packed struct.
- Sub-module instr_decode: combinational field split plus is_load/is_store/is_halt flags.

Test Plan:
- Reset with run = 1 while clkreset = 0 -> pc = 0, all outputs 0. Release reset -> imem_req rises on the next edge.
- R-type 32'h0008_6102 (rs=1, rd=2, funct=3, rt=4), zero-wait ack -> ra1 = 1, ra2 = 4, wa = 2, alu_opsel = 1, alu_mode = 1, ms1 = 0, single rf_we pulse in cycle 4, pc 0->1.
- LOAD 32'h0021_C287 (rs=3, rd=5, imm=0x10), dmem_ack delayed 3 cycles -> dmem_req high 3 cycles, dmem_we = 0, then ms2 = 1 with one rf_we pulse at wa = 5.
- STORE 32'h0011_E307 (rs=3, rd=6, imm=8) -> ms1 = 1, ra2 = 6, dmem_req = dmem_we = 1 until ack, rf_we never asserted.
- R-type with rd = 0, and pc = 63 -> no rf_we; pc wraps to 0. Next fetch HALT_WORD -> halted = 1, imem_req stays 0.
- Drop run during EXEC -> instruction retires, FSM goes to IDLE, imem_req = 0. Assert clkreset low mid-MEM -> dmem_req drops asynchronously.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and instruction-format constants for the multi-cycle sequencer.
package proc_ctrl_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_W     = 6;
  localparam int unsigned FUNCT_W   = 4;
  localparam int unsigned IMM_W     = 15;
  localparam int unsigned TYPE_POS  = 0;
  localparam int unsigned RS_POS    = 1;
  localparam int unsigned RD_POS    = 7;
  localparam int unsigned FUNCT_POS = 13;
  localparam int unsigned RT_POS    = 17;
  localparam int unsigned IMM_POS   = 17;

  localparam logic [FUNCT_W-1:0] FUNCT_LOAD  = 4'hE;
  localparam logic [FUNCT_W-1:0] FUNCT_STORE = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  // upper holds rt in its low bits for R-type, the immediate for I-type
  typedef struct packed {
    logic [IMM_W-1:0]   upper;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic               itype;
  } instr_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of an instruction word into fields and class flags.
module instr_decode
  import proc_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  instr_t             instr,
  output logic               itype_c,
  output logic [REG_W-1:0]   rs_c,
  output logic [REG_W-1:0]   rd_c,
  output logic [REG_W-1:0]   rt_c,
  output logic [FUNCT_W-1:0] funct_c,
  output logic [IMM_W-1:0]   imm_c,
  output logic               is_load_c,
  output logic               is_store_c,
  output logic               is_halt_c
);

  logic [INSTR_W-1:0] raw;

  assign raw        = instr;
  assign itype_c    = raw[TYPE_POS];
  assign rs_c       = raw[RS_POS +: REG_W];
  assign rd_c       = raw[RD_POS +: REG_W];
  assign rt_c       = raw[RT_POS +: REG_W];
  assign funct_c    = raw[FUNCT_POS +: FUNCT_W];
  assign imm_c      = raw[IMM_POS +: IMM_W];
  assign is_load_c  = itype_c && (funct_c == FUNCT_LOAD);
  assign is_store_c = itype_c && (funct_c == FUNCT_STORE);
  assign is_halt_c  = (raw == HALT_WORD);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC.
// Optional performance counters are enabled with CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W      = 6,
  parameter int unsigned RESET_PC  = 0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            clkreset,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [5:0]      ra1,
  output logic [5:0]      ra2,
  output logic [5:0]      wa,
  output logic            rf_we,
  output logic [2:0]      alu_opsel,
  output logic            alu_mode,
  output logic [14:0]     imm,
  output logic            ms1,
  output logic            ms2,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt
`endif
);

  state_t            state_q, state_d;
  instr_t            ir_q;
  logic [PC_W-1:0]   pc_q;
  logic              retire_c;

  logic               itype, is_load, is_store, is_halt;
  logic [REG_W-1:0]   rs, rd, rt;
  logic [FUNCT_W-1:0] funct;
  logic [IMM_W-1:0]   imm_raw;

  logic imem_req_d, dmem_req_d, dmem_we_d, rf_we_d, ms1_d, ms2_d, halted_d;

  instr_decode #(.HALT_WORD(HALT_WORD)) u_dec (
    .instr      (ir_q),
    .itype_c    (itype),
    .rs_c       (rs),
    .rd_c       (rd),
    .rt_c       (rt),
    .funct_c    (funct),
    .imm_c      (imm_raw),
    .is_load_c  (is_load),
    .is_store_c (is_store),
    .is_halt_c  (is_halt)
  );

  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (imem_ack) state_d = DECODE;
      DECODE: state_d = is_halt ? HALT : EXEC;
      EXEC:   state_d = (is_load || is_store) ? MEM : WB;
      MEM: begin
        if (dmem_ack) begin
          if (is_store) retire_c = 1'b1;
          else          state_d  = WB;
        end
      end
      WB:     retire_c = 1'b1;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (retire_c) state_d = run ? FETCH : IDLE;
  end

  // Control outputs are computed for the upcoming state and registered.
  always_comb begin
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    rf_we_d    = 1'b0;
    ms1_d      = 1'b0;
    ms2_d      = 1'b0;
    halted_d   = 1'b0;
    case (state_d)
      FETCH: imem_req_d = 1'b1;
      EXEC:  ms1_d = itype;
      MEM: begin
        dmem_req_d = 1'b1;
        dmem_we_d  = is_store;
        ms1_d      = itype;
      end
      WB: begin
        rf_we_d = (rd != '0);
        ms1_d   = itype;
        ms2_d   = is_load;
      end
      HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) begin
      pc_q     <= PC_W'(RESET_PC);
      ir_q     <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      ms1      <= 1'b0;
      ms2      <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (state_q == FETCH && imem_ack) ir_q <= instr_t'(imem_rdata);
      if (retire_c) pc_q <= pc_q + PC_W'(1);
      imem_req <= imem_req_d;
      dmem_req <= dmem_req_d;
      dmem_we  <= dmem_we_d;
      rf_we    <= rf_we_d;
      ms1      <= ms1_d;
      ms2      <= ms2_d;
      halted   <= halted_d;
    end
  end

  // Fields come straight from the IR, so they hold from DECODE until the next fetch.
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ra1       = rs;
  assign ra2       = itype ? rd : rt;
  assign wa        = rd;
  assign imm       = imm_raw;
  assign alu_opsel = funct[3:1];
  assign alu_mode  = funct[0];

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state_q != IDLE && state_q != HALT && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire_c && ret_cnt != '1) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table with a retire scoreboard plus corner sequences.
module tb_multicycle_ctrl;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        clkreset;
  logic        run;
  logic [5:0]  pc;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  ra1, ra2, wa;
  logic        rf_we;
  logic [2:0]  alu_opsel;
  logic        alu_mode;
  logic [14:0] imm;
  logic        ms1, ms2;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        halted;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .clkreset   (clkreset),
    .run        (run),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ra1        (ra1),
    .ra2        (ra2),
    .wa         (wa),
    .rf_we      (rf_we),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .imm        (imm),
    .ms1        (ms1),
    .ms2        (ms2),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .halted     (halted)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  typedef struct {
    logic [31:0] word;
    int          dreq;
    bit          we;
    int          rfw;
    int          cycles;
    logic [5:0]  ra1;
    logic [5:0]  ra2;
    logic [5:0]  wa;
    logic [14:0] imm;
    logic [2:0]  opsel;
    logic        mode;
    logic        ms1;
    logic        ms2;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [5:0] pc_next;
  } sb_t;

  vec_t       vecs[7];
  sb_t        sb[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [5:0] exp_pc;
  int         bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its FETCH cycle up to the cycle where pc moves.
  task automatic exec_one(input vec_t v);
    logic [5:0] pc0;
    int cyc = 0, dreq = 0, dwe = 0, rfw = 0, fetches = 0;
    logic ms1_l = 1'b0, ms2_l = 1'b0;
    bit done = 1'b0;
    sb_t e;
    pc0 = pc;
    for (int k = 0; k < 64 && !done; k++) begin
      if (pc != pc0) begin
        done = 1'b1;
      end else begin
        cyc++;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (imem_req) begin
          fetches++;
          imem_ack   = 1'b1;
          imem_rdata = v.word;
          if (fetches == 1) begin
            check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
            sb.push_back('{v: v, pc_next: exp_pc + 6'd1});
          end
        end
        if (dmem_req) begin
          dreq++;
          if (dmem_we) dwe++;
          if (dreq >= v.dreq) dmem_ack = 1'b1;
        end
        if (rf_we) rfw++;
        ms1_l = ms1;
        ms2_l = ms2;
        tick();
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check("retire_seen", 32'(done), 32'd1);
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc_next",   32'(pc),        32'(e.pc_next));
      check("cycles",    32'(cyc),       32'(e.v.cycles));
      check("fetches",   32'(fetches),   32'd1);
      check("dreq_cyc",  32'(dreq),      32'(e.v.dreq));
      check("dwe_cyc",   32'(dwe),       32'(e.v.we ? e.v.dreq : 0));
      check("rf_we_cnt", 32'(rfw),       32'(e.v.rfw));
      check("ms1",       32'(ms1_l),     32'(e.v.ms1));
      check("ms2",       32'(ms2_l),     32'(e.v.ms2));
      check("ra1",       32'(ra1),       32'(e.v.ra1));
      check("ra2",       32'(ra2),       32'(e.v.ra2));
      check("wa",        32'(wa),        32'(e.v.wa));
      check("imm",       32'(imm),       32'(e.v.imm));
      check("alu_opsel", 32'(alu_opsel), 32'(e.v.opsel));
      check("alu_mode",  32'(alu_mode),  32'(e.v.mode));
      exp_pc = e.pc_next;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{word: 32'h0008_6102, dreq: 0, we: 1'b0, rfw: 1, cycles: 4, ra1: 6'd1, ra2: 6'd4,
                wa: 6'd2, imm: 15'h0004, opsel: 3'd1, mode: 1'b1, ms1: 1'b0, ms2: 1'b0};
    vecs[1] = '{word: 32'h0021_C287, dreq: 3, we: 1'b0, rfw: 1, cycles: 7, ra1: 6'd3, ra2: 6'd5,
                wa: 6'd5, imm: 15'h0010, opsel: 3'd7, mode: 1'b0, ms1: 1'b1, ms2: 1'b1};
    vecs[2] = '{word: 32'h0011_E307, dreq: 2, we: 1'b1, rfw: 0, cycles: 5, ra1: 6'd3, ra2: 6'd6,
                wa: 6'd6, imm: 15'h0008, opsel: 3'd7, mode: 1'b1, ms1: 1'b1, ms2: 1'b0};
    vecs[3] = '{word: 32'h0011_E307, dreq: 1, we: 1'b1, rfw: 0, cycles: 4, ra1: 6'd3, ra2: 6'd6,
                wa: 6'd6, imm: 15'h0008, opsel: 3'd7, mode: 1'b1, ms1: 1'b1, ms2: 1'b0};
    vecs[4] = '{word: 32'h0021_C287, dreq: 1, we: 1'b0, rfw: 1, cycles: 5, ra1: 6'd3, ra2: 6'd5,
                wa: 6'd5, imm: 15'h0010, opsel: 3'd7, mode: 1'b0, ms1: 1'b1, ms2: 1'b1};
    vecs[5] = '{word: 32'hFFFE_C48F, dreq: 0, we: 1'b0, rfw: 1, cycles: 4, ra1: 6'd7, ra2: 6'd9,
                wa: 6'd9, imm: 15'h7FFF, opsel: 3'd3, mode: 1'b0, ms1: 1'b1, ms2: 1'b0};
    vecs[6] = '{word: 32'hFFFF_400A, dreq: 0, we: 1'b0, rfw: 0, cycles: 4, ra1: 6'd5, ra2: 6'd63,
                wa: 6'd0, imm: 15'h7FFF, opsel: 3'd5, mode: 1'b0, ms1: 1'b0, ms2: 1'b0};

    clkreset   = 1'b1;
    run        = 1'b1;
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = '0;
    exp_pc     = 6'd0;
    #2 clkreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_ctrl", 32'({imem_req, dmem_req, dmem_we, rf_we, ms1, ms2, halted}), 32'd0);
    check("rst_regs", 32'({ra1, ra2, wa}), 32'd0);
    check("rst_alu", 32'({imm, alu_opsel, alu_mode}), 32'd0);
    clkreset = 1'b1;
    #1;
    check("rel_req_before_edge", 32'(imem_req), 32'd0);
    tick();
    check("rel_req_after_edge", 32'(imem_req), 32'd1);

    for (int i = 0; i < 7; i++) exec_one(vecs[i]);
    while (exp_pc != 6'd63) exec_one(vecs[0]);
    exec_one(vecs[6]);
    check("pc_wrap", 32'(pc), 32'd0);

    // HALT word: halted rises two cycles after fetch and nothing else moves
    check("halt_fetch_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = HALT_W;
    tick();
    imem_ack = 1'b0;
    check("halt_decode_req", 32'(imem_req), 32'd0);
    tick();
    check("halted", 32'(halted), 32'd1);
    bad = 0;
    imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_req || !halted || pc != 6'd0 || rf_we || dmem_req) bad++;
    end
    imem_ack = 1'b0;
    check("halt_hold", 32'(bad), 32'd0);

    clkreset = 1'b0;
    #1;
    check("rst_clears_halted", 32'(halted), 32'd0);
    check("rst2_pc", 32'(pc), 32'd0);
    tick();
    clkreset = 1'b1;
    tick();
    check("rst2_fetch", 32'(imem_req), 32'd1);
    exp_pc = 6'd0;

    // Drop run during EXEC: instruction retires then parks in IDLE
    imem_ack   = 1'b1;
    imem_rdata = vecs[0].word;
    tick();
    imem_ack = 1'b0;
    tick();
    check("drop_exec_ms1", 32'(ms1), 32'd0);
    run = 1'b0;
    tick();
    check("drop_wb_we", 32'(rf_we), 32'd1);
    tick();
    check("drop_pc", 32'(pc), 32'd1);
    check("drop_idle_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_req || dmem_req || rf_we || pc != 6'd1) bad++;
    end
    check("idle_ignores_ack", 32'(bad), 32'd0);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    run = 1'b1;
    tick();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", 32'(imem_addr), 32'd1);

    // Reset while stalled in MEM aborts the LOAD with no writeback
    imem_ack   = 1'b1;
    imem_rdata = vecs[1].word;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    check("abort_mem_req", 32'(dmem_req), 32'd1);
    tick();
    check("abort_mem_hold", 32'({dmem_req, dmem_we}), 32'b10);
    #2;
    clkreset = 1'b0;
    #1;
    check("abort_dreq_async", 32'(dmem_req), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_we", 32'(rf_we), 32'd0);
    run = 1'b0;
    @(posedge clk);
    #1;
    clkreset = 1'b1;
    tick();
    check("abort_idle", 32'({imem_req, dmem_req, rf_we, halted}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
